// File: rtl/lap_timer_pkg.sv
// Shared types, default sizes and the next-state rule for the lap timer.
// Types:     state_t (IDLE, COUNTING, PAUSED, SPLIT).
// Constants: DEF_CNT_W, DEF_LAP_DEPTH. Function: lap_next_state.
package lap_timer_pkg;

  typedef enum logic [1:0] {IDLE, COUNTING, PAUSED, SPLIT} state_t;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_LAP_DEPTH = 8;

  // Button decode. trig always wins over split when both arrive together.
  function automatic state_t lap_next_state(state_t s, logic trig, logic split);
    state_t n;
    n = s;
    case (s)
      IDLE:     if (trig) n = COUNTING;
      COUNTING: if (trig) n = PAUSED; else if (split) n = SPLIT;
      SPLIT:    if (trig) n = PAUSED; else if (split) n = COUNTING;
      PAUSED:   if (trig) n = COUNTING; else if (split) n = IDLE;
      default:  n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lap_timer_ctl_if.sv
// Button/time-base inputs and display/lap outputs of the lap timer.
// Inputs:  trig, split, tick, lap_rd_idx.
// Outputs: init_regs, count_enabled, split_active, count, disp, lap_count, lap_full, lap_rd_data, overflow.
interface lap_timer_ctl_if
  import lap_timer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LAP_DEPTH = DEF_LAP_DEPTH
) ();
  localparam int LAP_IDX_W = $clog2(LAP_DEPTH);

  logic                 trig;
  logic                 split;
  logic                 tick;
  logic [LAP_IDX_W-1:0] lap_rd_idx;
  logic                 init_regs;
  logic                 count_enabled;
  logic                 split_active;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     disp;
  logic [LAP_IDX_W:0]   lap_count;
  logic                 lap_full;
  logic [CNT_W-1:0]     lap_rd_data;
  logic                 overflow;

  // master: button/debounce side plus display reader
  modport master (
    output trig, split, tick, lap_rd_idx,
    input  init_regs, count_enabled, split_active, count, disp,
    input  lap_count, lap_full, lap_rd_data, overflow
  );

  // slave: the timer itself
  modport slave (
    input  trig, split, tick, lap_rd_idx,
    output init_regs, count_enabled, split_active, count, disp,
    output lap_count, lap_full, lap_rd_data, overflow
  );
endinterface

// File: rtl/lap_buffer.sv
// Lap memory: write-pointer register array with a guarded combinational read.
// Ports: clk, reset, clr (sync pointer clear), wr_en/wr_data, rd_idx/rd_data, lap_count, lap_full.
// Writes are dropped once full; only the pointer clears, so stale entries hide behind the index guard.
module lap_buffer
  import lap_timer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LAP_DEPTH = DEF_LAP_DEPTH,
  parameter int LAP_IDX_W = $clog2(LAP_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [CNT_W-1:0]     wr_data,
  input  logic [LAP_IDX_W-1:0] rd_idx,
  output logic [LAP_IDX_W:0]   lap_count,
  output logic                 lap_full,
  output logic [CNT_W-1:0]     rd_data
);
  localparam logic [LAP_IDX_W:0] DEPTH_V = (LAP_IDX_W+1)'(LAP_DEPTH);

  logic [CNT_W-1:0] mem [LAP_DEPTH];

  assign lap_full = (lap_count == DEPTH_V);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      lap_count <= '0;
    end else if (wr_en && !lap_full) begin
      lap_count <= lap_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !lap_full && !reset && !clr) begin
      mem[lap_count[LAP_IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_idx} < lap_count) ? mem[rd_idx] : '0;

endmodule

// File: rtl/lap_timer_ctl.sv
// Stopwatch controller: FSM, tick counter, split display hold, overflow and lap capture.
// Ports: clk, reset (sync, active-high), bus (lap_timer_ctl_if.slave).
// Build option LAP_TIMER_SATURATE_EN: saturate with sticky overflow; otherwise wrap with a one-cycle pulse.
module lap_timer_ctl
  import lap_timer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LAP_DEPTH = DEF_LAP_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  lap_timer_ctl_if.slave  bus
);
  localparam int LAP_IDX_W = $clog2(LAP_DEPTH);

  state_t           state;
  state_t           state_nx;
  logic             init_q, en_q, split_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] hold;
  logic             overflow;
  logic             lap_cap, clear_all, inc, at_max;

  assign state_nx  = lap_next_state(state, bus.trig, bus.split);
  assign lap_cap   = (state == COUNTING) && bus.split && !bus.trig;
  assign clear_all = (state == PAUSED) && bus.split && !bus.trig;
  assign inc       = ((state == COUNTING) || (state == SPLIT)) && bus.tick;
  assign at_max    = (count == {CNT_W{1'b1}});

  // Moore flags are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      init_q  <= 1'b1;
      en_q    <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state   <= state_nx;
      init_q  <= (state_nx == IDLE);
      en_q    <= (state_nx == COUNTING) || (state_nx == SPLIT);
      split_q <= (state_nx == SPLIT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_all || (state == IDLE)) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
`ifdef LAP_TIMER_SATURATE_EN
      if (inc && !at_max) begin
        count <= count + 1'b1;
      end else if (inc) begin
        overflow <= 1'b1;
      end
`else
      if (inc) begin
        count <= count + 1'b1;
      end
      overflow <= inc && at_max;
`endif
    end
  end

  // Display hold takes the pre-edge count, so a same-edge tick is excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
    end else if (lap_cap) begin
      hold <= count;
    end
  end

  lap_buffer #(
    .CNT_W     (CNT_W),
    .LAP_DEPTH (LAP_DEPTH),
    .LAP_IDX_W (LAP_IDX_W)
  ) u_lap_buffer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clear_all),
    .wr_en     (lap_cap),
    .wr_data   (count),
    .rd_idx    (bus.lap_rd_idx),
    .lap_count (bus.lap_count),
    .lap_full  (bus.lap_full),
    .rd_data   (bus.lap_rd_data)
  );

  assign bus.init_regs     = init_q;
  assign bus.count_enabled = en_q;
  assign bus.split_active  = split_q;
  assign bus.count         = count;
  assign bus.disp          = split_q ? hold : count;
  assign bus.overflow      = overflow;

endmodule

// File: tb/tb_lap_timer_ctl.sv
// Bench for lap_timer_ctl with CNT_W=4, LAP_DEPTH=8: directed scenarios then randomized traffic.
// Expected values come from fixed constants and a queue-based behavioural model.
// Honours LAP_TIMER_SATURATE_EN in the same way as the design.
module tb_lap_timer_ctl;
  localparam int CNT_W = 4;
  localparam int LAP_DEPTH = 8;
  localparam int IDX_W = $clog2(LAP_DEPTH);
  localparam int MAXV = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SPL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lap_timer_ctl_if #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) bus ();

  lap_timer_ctl #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // behavioural model
  int m_mode = M_IDLE;
  int m_cnt = 0;
  int m_hold = 0;
  int m_ovf = 0;
  int m_laps[$];
  int m_idx = 0;

  task automatic model_step(input logic t, input logic s, input logic k, input logic r);
    int old;
    bit running;
    old = m_cnt;
    if (r) begin
      m_mode = M_IDLE; m_cnt = 0; m_hold = 0; m_ovf = 0; m_laps.delete();
      return;
    end
    running = (m_mode == M_RUN) || (m_mode == M_SPL);
    if (running && k) begin
`ifdef LAP_TIMER_SATURATE_EN
      if (old == MAXV) m_ovf = 1;
      else m_cnt = old + 1;
`else
      m_cnt = (old + 1) % (MAXV + 1);
`endif
    end
`ifndef LAP_TIMER_SATURATE_EN
    m_ovf = (running && k && old == MAXV) ? 1 : 0;
`endif
    case (m_mode)
      M_IDLE:  if (t) m_mode = M_RUN;
      M_RUN: begin
        if (t) m_mode = M_PAUSE;
        else if (s) begin
          if (m_laps.size() < LAP_DEPTH) m_laps.push_back(old);
          m_hold = old;
          m_mode = M_SPL;
        end
      end
      M_SPL: begin
        if (t) m_mode = M_PAUSE;
        else if (s) m_mode = M_RUN;
      end
      default: begin
        if (t) m_mode = M_RUN;
        else if (s) begin
          m_mode = M_IDLE; m_cnt = 0; m_ovf = 0; m_laps.delete();
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs at negedge, step the model at posedge, leave #1 for sampling.
  task automatic drive(input logic t, input logic s, input logic k, input logic r, input int idx);
    @(negedge clk);
    bus.trig = t; bus.split = s; bus.tick = k; reset = r;
    bus.lap_rd_idx = IDX_W'(idx);
    m_idx = idx;
    @(posedge clk);
    model_step(t, s, k, r);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1, 0);
    vectors++; if (bus.init_regs !== 1'b1) begin miscompares++; $display("FAIL reset_init_regs got %b want 1", bus.init_regs); end
    vectors++; if (bus.count_enabled !== 1'b0) begin miscompares++; $display("FAIL reset_count_enabled got %b want 0", bus.count_enabled); end
    vectors++; if (bus.split_active !== 1'b0) begin miscompares++; $display("FAIL reset_split_active got %b want 0", bus.split_active); end
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.count); end
    vectors++; if (bus.disp !== 4'd0) begin miscompares++; $display("FAIL reset_disp got %0d want 0", bus.disp); end
    vectors++; if (bus.lap_count !== 4'd0) begin miscompares++; $display("FAIL reset_lap_count got %0d want 0", bus.lap_count); end
    vectors++; if (bus.lap_full !== 1'b0) begin miscompares++; $display("FAIL reset_lap_full got %b want 0", bus.lap_full); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
  endtask

  task automatic test_start_pause();
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    vectors++; if (bus.count_enabled !== 1'b1) begin miscompares++; $display("FAIL start_count_enabled got %b want 1", bus.count_enabled); end
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    vectors++; if (bus.count !== 4'd5) begin miscompares++; $display("FAIL pause_count got %0d want 5", bus.count); end
    vectors++; if (bus.disp !== 4'd5) begin miscompares++; $display("FAIL pause_disp got %0d want 5", bus.disp); end
    vectors++; if (bus.init_regs !== 1'b0) begin miscompares++; $display("FAIL pause_init_regs got %b want 0", bus.init_regs); end
    vectors++; if (bus.count_enabled !== 1'b0) begin miscompares++; $display("FAIL pause_count_enabled got %b want 0", bus.count_enabled); end
  endtask

  task automatic test_trig_split_same();
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    vectors++; if (bus.split_active !== 1'b0) begin miscompares++; $display("FAIL both_split_active got %b want 0", bus.split_active); end
    vectors++; if (bus.count_enabled !== 1'b0) begin miscompares++; $display("FAIL both_count_enabled got %b want 0", bus.count_enabled); end
    vectors++; if (bus.lap_count !== 4'd0) begin miscompares++; $display("FAIL both_lap_count got %0d want 0", bus.lap_count); end
    vectors++; if (bus.count !== 4'd2) begin miscompares++; $display("FAIL both_count got %0d want 2", bus.count); end
  endtask

  task automatic test_split_tick();
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    vectors++; if (bus.lap_rd_data !== 4'd7) begin miscompares++; $display("FAIL split_lap0 got %0d want 7", bus.lap_rd_data); end
    vectors++; if (bus.count !== 4'd8) begin miscompares++; $display("FAIL split_count got %0d want 8", bus.count); end
    vectors++; if (bus.disp !== 4'd7) begin miscompares++; $display("FAIL split_disp got %0d want 7", bus.disp); end
    vectors++; if (bus.split_active !== 1'b1) begin miscompares++; $display("FAIL split_active got %b want 1", bus.split_active); end
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
    vectors++; if (bus.count !== 4'd11) begin miscompares++; $display("FAIL split_live_count got %0d want 11", bus.count); end
    vectors++; if (bus.disp !== 4'd7) begin miscompares++; $display("FAIL split_frozen_disp got %0d want 7", bus.disp); end
    drive(0, 1, 0, 0, 0);
    vectors++; if (bus.disp !== 4'd11) begin miscompares++; $display("FAIL release_disp got %0d want 11", bus.disp); end
    vectors++; if (bus.split_active !== 1'b0) begin miscompares++; $display("FAIL release_split_active got %b want 0", bus.split_active); end
  endtask

  task automatic test_lap_full();
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      drive(0, 0, 1, 0, 0);
      drive(0, 1, 0, 0, 0);
      if (i < 9) drive(0, 1, 0, 0, 0);
    end
    vectors++; if (bus.lap_count !== 4'd8) begin miscompares++; $display("FAIL full_lap_count got %0d want 8", bus.lap_count); end
    vectors++; if (bus.lap_full !== 1'b1) begin miscompares++; $display("FAIL full_flag got %b want 1", bus.lap_full); end
    vectors++; if (bus.split_active !== 1'b1) begin miscompares++; $display("FAIL full_split_active got %b want 1", bus.split_active); end
    drive(0, 0, 0, 0, 7);
    vectors++; if (bus.lap_rd_data !== 4'd8) begin miscompares++; $display("FAIL full_lap7 got %0d want 8", bus.lap_rd_data); end
    drive(0, 1, 0, 0, 7);
    vectors++; if (bus.split_active !== 1'b0) begin miscompares++; $display("FAIL full_leave_split got %b want 0", bus.split_active); end
    drive(0, 1, 0, 0, 7);
    vectors++; if (bus.split_active !== 1'b1) begin miscompares++; $display("FAIL full_reenter_split got %b want 1", bus.split_active); end
    vectors++; if (bus.lap_count !== 4'd8) begin miscompares++; $display("FAIL full_lap_count_hold got %0d want 8", bus.lap_count); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp16, exp17;
    logic       ovf16, ovf17;
`ifdef LAP_TIMER_SATURATE_EN
    exp16 = 4'd15; ovf16 = 1'b1; exp17 = 4'd15; ovf17 = 1'b1;
`else
    exp16 = 4'd0;  ovf16 = 1'b1; exp17 = 4'd1;  ovf17 = 1'b0;
`endif
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 1, 0, 0);
    vectors++; if (bus.count !== 4'd15) begin miscompares++; $display("FAIL ovf_t15_count got %0d want 15", bus.count); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_t15_flag got %b want 0", bus.overflow); end
    drive(0, 0, 1, 0, 0);
    vectors++; if (bus.count !== exp16) begin miscompares++; $display("FAIL ovf_t16_count got %0d want %0d", bus.count, exp16); end
    vectors++; if (bus.overflow !== ovf16) begin miscompares++; $display("FAIL ovf_t16_flag got %b want %b", bus.overflow, ovf16); end
    drive(0, 0, 1, 0, 0);
    vectors++; if (bus.count !== exp17) begin miscompares++; $display("FAIL ovf_t17_count got %0d want %0d", bus.count, exp17); end
    vectors++; if (bus.overflow !== ovf17) begin miscompares++; $display("FAIL ovf_t17_flag got %b want %b", bus.overflow, ovf17); end
  endtask

  task automatic test_clear();
    // continues from the overflow scenario, still counting
    drive(0, 1, 0, 0, 0);
    vectors++; if (bus.lap_count !== 4'd1) begin miscompares++; $display("FAIL clr_lap_before got %0d want 1", bus.lap_count); end
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL clr_count got %0d want 0", bus.count); end
    vectors++; if (bus.lap_count !== 4'd0) begin miscompares++; $display("FAIL clr_lap_count got %0d want 0", bus.lap_count); end
    vectors++; if (bus.lap_rd_data !== 4'd0) begin miscompares++; $display("FAIL clr_lap_rd got %0d want 0", bus.lap_rd_data); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow got %b want 0", bus.overflow); end
    vectors++; if (bus.init_regs !== 1'b1) begin miscompares++; $display("FAIL clr_init_regs got %b want 1", bus.init_regs); end
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0);
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL rstsplit_count got %0d want 0", bus.count); end
    vectors++; if (bus.disp !== 4'd0) begin miscompares++; $display("FAIL rstsplit_disp got %0d want 0", bus.disp); end
    vectors++; if (bus.lap_count !== 4'd0) begin miscompares++; $display("FAIL rstsplit_lap_count got %0d want 0", bus.lap_count); end
    vectors++; if (bus.lap_rd_data !== 4'd0) begin miscompares++; $display("FAIL rstsplit_lap_rd got %0d want 0", bus.lap_rd_data); end
    vectors++; if (bus.split_active !== 1'b0) begin miscompares++; $display("FAIL rstsplit_split_active got %b want 0", bus.split_active); end
    vectors++; if (bus.init_regs !== 1'b1) begin miscompares++; $display("FAIL rstsplit_init_regs got %b want 1", bus.init_regs); end
  endtask

  task automatic test_random();
    int exp_rd;
    drive(0, 0, 0, 1, 0);
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(5) == 0), ($urandom_range(4) == 0), ($urandom_range(1) == 0),
            ($urandom_range(150) == 0), $urandom_range(LAP_DEPTH - 1));
      exp_rd = (m_idx < m_laps.size()) ? m_laps[m_idx] : 0;
      vectors++; if (bus.init_regs !== (m_mode == M_IDLE)) begin miscompares++; $display("FAIL rnd_init_regs cyc %0d got %b want %b", c, bus.init_regs, (m_mode == M_IDLE)); end
      vectors++; if (bus.count_enabled !== (m_mode == M_RUN || m_mode == M_SPL)) begin miscompares++; $display("FAIL rnd_count_enabled cyc %0d got %b want %b", c, bus.count_enabled, (m_mode == M_RUN || m_mode == M_SPL)); end
      vectors++; if (bus.split_active !== (m_mode == M_SPL)) begin miscompares++; $display("FAIL rnd_split_active cyc %0d got %b want %b", c, bus.split_active, (m_mode == M_SPL)); end
      vectors++; if (bus.count !== 4'(m_cnt)) begin miscompares++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, bus.count, m_cnt); end
      vectors++; if (bus.disp !== 4'((m_mode == M_SPL) ? m_hold : m_cnt)) begin miscompares++; $display("FAIL rnd_disp cyc %0d got %0d want %0d", c, bus.disp, (m_mode == M_SPL) ? m_hold : m_cnt); end
      vectors++; if (bus.lap_count !== 4'(m_laps.size())) begin miscompares++; $display("FAIL rnd_lap_count cyc %0d got %0d want %0d", c, bus.lap_count, m_laps.size()); end
      vectors++; if (bus.lap_full !== (m_laps.size() == LAP_DEPTH)) begin miscompares++; $display("FAIL rnd_lap_full cyc %0d got %b want %b", c, bus.lap_full, (m_laps.size() == LAP_DEPTH)); end
      vectors++; if (bus.lap_rd_data !== 4'(exp_rd)) begin miscompares++; $display("FAIL rnd_lap_rd idx %0d cyc %0d got %0d want %0d", m_idx, c, bus.lap_rd_data, exp_rd); end
      vectors++; if (bus.overflow !== (m_ovf != 0)) begin miscompares++; $display("FAIL rnd_overflow cyc %0d got %b want %0d", c, bus.overflow, m_ovf); end
    end
  endtask

  initial begin
    bus.trig = 1'b0; bus.split = 1'b0; bus.tick = 1'b0; bus.lap_rd_idx = '0;
    test_reset();
    test_start_pause();
    test_trig_split_same();
    test_split_tick();
    test_lap_full();
    test_overflow();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
